alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 32-bit combinational ALU (ops 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor) between two requesters.
- Arbitration is round-robin; each transaction runs as accept -> issue -> respond.
- Operands are latched before they drive the ALU, and the result/zero flag are registered into a shared response channel tagged with the requester id.
- Sits between the ALU and its clients (e.g. execute stage and address-generation unit).

Parameters:
- WIDTH, 32, operand/result width; must match the ALU data width.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- r0_valid  input  1  requester 0 request valid.
- r0_ready  output  1  requester 0 request accepted this cycle.
- r0_a  input  WIDTH  requester 0 operand A.
- r0_b  input  WIDTH  requester 0 operand B.
- r0_op  input  3  requester 0 op code.
- r1_valid, r1_ready, r1_a, r1_b, r1_op: same as r0_*, for requester 1.
- alu_a  output  WIDTH  operand A to ALU.
- alu_b  output  WIDTH  operand B to ALU.
- alu_op  output  3  op code to ALU.
- alu_result  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- resp_valid  output  1  response valid.
- resp_ready  input  1  response consumer ready.
- resp_id  output  1  requester that owns the response (0/1).
- resp_result  output  WIDTH  registered ALU result.
- resp_zero  output  1  registered ALU zero flag.
- resp_err  output  1  op code was 110 or 111 (undefined op).
- done_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state=IDLE; r0_ready=r1_ready=0; resp_valid=0; resp_id=0; resp_result=0; resp_zero=0; resp_err=0; done_count=0; alu_a=alu_b=0; alu_op=000; last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE: no transaction in flight.
  - ISSUE: latched operands drive the ALU.
  - RESP: response held.
- Handshake: a request transfers on rX_valid & rX_ready. rX_ready is combinational and high only in IDLE, only for the granted requester. At most one ready is high per cycle. Requesters must hold valid/a/b/op stable until accepted. Valid may not be withdrawn before acceptance.
- Grant, in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On accept: latch a, b, op and id; set last_grant=id; go to ISSUE.
- ISSUE, exactly 1 cycle:
  - alu_a/alu_b/alu_op come from the latch registers, which hold their value outside ISSUE as well.
  - At the clock edge, capture alu_result -> resp_result and alu_zero -> resp_zero.
  - Set resp_err = (op==110 || op==111). Undefined ops are still issued; the ALU returns 0 and zero=1.
  - Set resp_id, set resp_valid=1, go to RESP.
- RESP:
  - resp_* held stable while resp_valid & !resp_ready.
  - On resp_valid & resp_ready: resp_valid=0, done_count+=1, go to IDLE.
  - A new request cannot be accepted in the same cycle as the response handshake; it is accepted no earlier than the following cycle.
- Latency: accept at edge N; resp_valid high after edge N+1; fastest accept-to-accept spacing is 3 cycles (resp_ready tied high).
- done_count wraps from 2^CNT_W-1 to 0 without a flag.
- rst asserted in any state: abandons the in-flight transaction with no response, returns all outputs to reset values at the next edge; rX_ready is low while rst is high.
- Data width: the result is passed through unchanged; the block does no arithmetic on data.

Test Plan:
- Single request: r0 a=5, b=3, op=000 -> r0_ready in IDLE cycle, resp_valid 2 edges later, resp_id=0, resp_result=8, resp_zero=0, resp_err=0, done_count=1.
- Zero flag: r1 a=7, b=7, op=001 -> resp_id=1, resp_result=0, resp_zero=1.
- Contention after reset: both valid continuously, r0 op=010 a=0xF0F0 b=0xFF00, r1 op=011 a=0x0F b=0xF0, resp_ready=1 -> grant order r0, r1, r0, r1; results 0xF000 then 0xFF alternating; accepts spaced 3 cycles.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_* stable, r0_ready/r1_ready stay 0, done_count unchanged. On resp_ready=1 -> one handshake, done_count+1.
- Undefined op: r0 op=110 a=1 b=1 -> resp_result=0, resp_zero=1, resp_err=1. Op 101 with a=b=0 -> resp_result=0xFFFFFFFF, resp_err=0.
- Reset mid-operation: assert rst in ISSUE, and again in RESP -> next edge resp_valid=0, done_count=0, state IDLE. After release, r0 wins the first tie.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// requesters. Each transaction runs accept -> issue -> respond; operands are
// latched before driving the ALU and the result is registered into a shared,
// id-tagged response channel.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [2:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic [2:0]       lat_op;
  logic             lat_id;
  logic             last_grant;
  logic             gnt_any;
  logic             gnt_id;

  // Grant selection: only in IDLE and out of reset; on a tie the requester
  // that did not win last time is chosen.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE && !rst) begin
      if (r0_valid && r1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = ~last_grant;
      end else if (r0_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (r1_valid) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign r0_ready = gnt_any & ~gnt_id;
  assign r1_ready = gnt_any &  gnt_id;

  // The ALU always sees the latch registers, which hold outside ISSUE too.
  assign alu_a  = lat_a;
  assign alu_b  = lat_b;
  assign alu_op = lat_op;

  // Next-state logic for the accept -> issue -> respond sequence.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand latch, response capture and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_a       <= '0;
      lat_b       <= '0;
      lat_op      <= '0;
      lat_id      <= 1'b0;
      last_grant  <= 1'b1;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
      done_count  <= '0;
    end else begin
      if (gnt_any) begin
        lat_a      <= gnt_id ? r1_a  : r0_a;
        lat_b      <= gnt_id ? r1_b  : r0_b;
        lat_op     <= gnt_id ? r1_op : r0_op;
        lat_id     <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == ISSUE) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_err    <= (lat_op == 3'b110) || (lat_op == 3'b111);
        resp_id     <= lat_id;
        resp_valid  <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        done_count <= done_count + 1'b1;
      end
    end
  end

endmodule
